// File: rtl/arb_mux_pkg.sv
// Shared constants and helpers for the arb_mux slice.
package arb_mux_pkg;

  // Default payload width and channel count.
  localparam int unsigned DefaultWidth = 32;
  localparam int unsigned DefaultN     = 4;

  // Width of a channel index for n channels. Never returns zero, so a
  // degenerate count still yields a legal vector.
  function automatic int unsigned sel_width(input int unsigned n);
    if (n <= 1) begin
      return 1;
    end
    return $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Grant logic for arb_mux: rotating pointer, first-valid search, one-hot and
// index grant outputs.
// Build option: ARB_MUX_FIXED_PRIO_EN selects fixed priority (lowest valid
// index wins) with the pointer held at zero.
module rr_arbiter
  import arb_mux_pkg::*;
#(
  parameter int unsigned N     = DefaultN,
  parameter int unsigned SEL_W = sel_width(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     gnt,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] base;
  logic [SEL_W:0]   sum;
  logic [SEL_W-1:0] cand;

  // Search origin: the rotating pointer, or channel 0 under fixed priority.
  always_comb begin
`ifdef ARB_MUX_FIXED_PRIO_EN
    base = '0;
`else
    base = ptr_q;
`endif
  end

  // First requester at or above base, wrapping from N-1 to 0.
  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    sum       = '0;
    cand      = '0;
    for (int off = 0; off < int'(N); off++) begin
      // One extra bit keeps base+off from overflowing before the wrap.
      sum = {1'b0, base} + (SEL_W+1)'(off);
      if (sum >= (SEL_W+1)'(N)) begin
        sum = sum - (SEL_W+1)'(N);
      end
      cand = sum[SEL_W-1:0];
      if (!gnt_valid && req[cand]) begin
        gnt_valid  = 1'b1;
        gnt[cand]  = 1'b1;
        gnt_idx    = cand;
      end
    end
  end

  // Pointer moves just past the winner only when its grant is taken.
  always_comb begin
    ptr_d = ptr_q;
`ifdef ARB_MUX_FIXED_PRIO_EN
    ptr_d = '0;
`else
    if (advance && gnt_valid) begin
      if (gnt_idx == SEL_W'(N - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = gnt_idx + 1'b1;
      end
    end
`endif
  end

  // Pointer register, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/arb_mux.sv
// N-to-1 arbitrating multiplexer with a one-entry registered output stage.
// Requesters are served round-robin; the winning payload and its channel
// index are captured one cycle after acceptance. Legal N is 2..16.
// Build option: ARB_MUX_FIXED_PRIO_EN switches arbitration to fixed priority.
module arb_mux
  import arb_mux_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned N     = DefaultN,
  parameter int unsigned SEL_W = sel_width(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_sel,
  input  logic               out_ready
);

  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic [SEL_W-1:0] out_sel_q;

  logic             load;
  logic             accept;
  logic [N-1:0]     gnt;
  logic [SEL_W-1:0] gnt_idx;
  logic             gnt_valid;
  logic [WIDTH-1:0] sel_data;

  // Output register can take a new word when empty or draining this cycle.
  assign load   = !out_valid_q || out_ready;
  assign accept = load && gnt_valid && !reset;

  rr_arbiter #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (in_valid),
    .advance   (accept),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  // Ready goes only to the granted channel, and never while in reset;
  // it is derived from valids and out_ready only, never from payload.
  always_comb begin
    in_ready = '0;
    if (load && !reset) begin
      in_ready = gnt;
    end
  end

  // One-hot payload select driven by the grant vector.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (gnt[i]) begin
        sel_data = sel_data | in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Output stage: capture on accept, clear valid when loading with no
  // winner, hold everything under backpressure.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else if (load) begin
      out_valid_q <= gnt_valid;
      if (gnt_valid) begin
        out_data_q <= sel_data;
        out_sel_q  <= gnt_idx;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_arb_mux.sv
// Scoreboard bench for arb_mux (N=4, WIDTH=32): the driver pushes the
// expected payload/index on every accepted grant, a monitor pops and compares
// on every output transfer.
module tb_arb_mux;

  localparam int unsigned W  = 32;
  localparam int unsigned NC = 4;

  typedef struct packed {
    logic [W-1:0] data;
    logic [1:0]   sel;
  } exp_t;

  logic            clk;
  logic            reset;
  logic [NC-1:0]   in_valid;
  logic [NC*W-1:0] in_data;
  logic [NC-1:0]   in_ready;
  logic            out_valid;
  logic [W-1:0]    out_data;
  logic [1:0]      out_sel;
  logic            out_ready;

  logic [W-1:0] chan [NC];
  exp_t         exp_q[$];
  int           checks = 0;
  int           errors = 0;

  arb_mux #(
    .WIDTH (W),
    .N     (NC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply one cycle of stimulus at the falling edge, check in_ready, and
  // record the payload the granted channel should deliver next cycle.
  task automatic drive(input logic rst, input logic [NC-1:0] vld, input logic ordy,
                       input logic [NC-1:0] exp_rdy);
    exp_t e;
    @(negedge clk);
    reset     = rst;
    in_valid  = vld;
    out_ready = ordy;
    #2;
    chk("in_ready", W'(in_ready), W'(exp_rdy));
    if (rst) begin
      exp_q.delete();
    end
    for (int i = 0; i < int'(NC); i++) begin
      if (exp_rdy[i]) begin
        e.data = chan[i];
        e.sel  = 2'(i);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic chk_out(input logic v, input logic [W-1:0] d, input logic [1:0] s);
    chk("out_valid", W'(out_valid), W'(v));
    chk("out_data", out_data, d);
    chk("out_sel", W'(out_sel), W'(s));
  endtask

  // Monitor: sampled mid-cycle, after the driver has settled its inputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (!reset && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow: got sel %0d data %h expected none", out_sel, out_data);
        end else begin
          e = exp_q.pop_front();
          chk("sb_data", out_data, e.data);
          chk("sb_sel", W'(out_sel), W'(e.sel));
        end
      end
    end
  end

  initial begin
    reset     = 1'b1;
    in_valid  = '0;
    out_ready = 1'b0;
    for (int i = 0; i < int'(NC); i++) begin
      chan[i] = 32'hC0DE_0000 + W'(i);
    end
    chan[2] = 32'hDEAD_BEEF;
    for (int i = 0; i < int'(NC); i++) begin
      in_data[i*W +: W] = chan[i];
    end

    // Reset: no ready even with every channel requesting.
    drive(1'b1, 4'b1111, 1'b1, 4'b0000);
    chk_out(1'b0, 32'h0, 2'd0);
    drive(1'b1, 4'b1111, 1'b1, 4'b0000);
    chk_out(1'b0, 32'h0, 2'd0);

    // Single request on channel 2, one-cycle latency.
    drive(1'b0, 4'b0100, 1'b1, 4'b0100);
    chk_out(1'b0, 32'h0, 2'd0);
    drive(1'b0, 4'b0000, 1'b1, 4'b0000);
    chk_out(1'b1, 32'hDEAD_BEEF, 2'd2);
    // Idle load: valid drops, data and index hold.
    drive(1'b0, 4'b0000, 1'b1, 4'b0000);
    chk_out(1'b0, 32'hDEAD_BEEF, 2'd2);

`ifdef ARB_MUX_FIXED_PRIO_EN
    // Fixed priority: channel 0 wins every cycle.
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 4'b1111, 1'b1, 4'b0001);
      if (k > 0) begin
        chk_out(1'b1, chan[0], 2'd0);
      end
    end
`else
    // Wrap: pointer at 3, only channel 0 requests; pointer then sits at 1.
    drive(1'b0, 4'b0001, 1'b1, 4'b0001);
    chk_out(1'b0, 32'hDEAD_BEEF, 2'd2);
    drive(1'b0, 4'b1111, 1'b1, 4'b0010);
    chk_out(1'b1, chan[0], 2'd0);

    // Fairness with all channels held: 2,3,0,1,2,3,0,1,2,3 with no gaps.
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 4'b1111, 1'b1, 4'(1 << ((k + 2) % 4)));
      chk("no_bubble", W'(out_valid), 32'd1);
      chk("rr_sel", W'(out_sel), W'((k + 1) % 4));
    end

    // Backpressure: channel 3 word held, no ready for three cycles.
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 4'b0011, 1'b0, 4'b0000);
      chk_out(1'b1, chan[3], 2'd3);
    end
    drive(1'b0, 4'b0011, 1'b1, 4'b0001);
    chk_out(1'b1, chan[3], 2'd3);
    drive(1'b0, 4'b0011, 1'b1, 4'b0010);
    chk_out(1'b1, chan[0], 2'd0);

    // Reset mid-stream discards the held channel 1 word.
    drive(1'b1, 4'b1010, 1'b0, 4'b0000);
    chk_out(1'b1, chan[1], 2'd1);
    // Post-reset search starts at channel 0, so channel 1 wins.
    drive(1'b0, 4'b1010, 1'b1, 4'b0010);
    chk_out(1'b0, 32'h0, 2'd0);
    drive(1'b0, 4'b0000, 1'b1, 4'b0000);
    chk_out(1'b1, chan[1], 2'd1);
`endif

    drive(1'b0, 4'b0000, 1'b1, 4'b0000);
    drive(1'b0, 4'b0000, 1'b1, 4'b0000);
    chk_out(1'b0, out_valid ? 32'hFFFF_FFFF : out_data, out_sel);
    chk("sb_empty", W'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/arb_mux.md
ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width per channel.
REQ-002 SHALL have parameter N, default 4, input channel count; legal range 2..16.
REQ-003 SHALL have parameter SEL_W, default $clog2(N), width of the select/grant index.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  N  per-channel request valid.
REQ-007 in_data  input  N x WIDTH  per-channel payload.
REQ-008 in_ready  output  N  per-channel accept; asserted for at most one channel per cycle.
REQ-009 out_valid  output  1  output register holds valid payload.
REQ-010 out_data  output  WIDTH  registered payload of the granted channel.
REQ-011 out_sel  output  SEL_W  registered index of the channel that supplied out_data.
REQ-012 out_ready  input  1  downstream accept.

Function
REQ-013 Transfer on an input channel i SHALL occur only in cycles where in_valid[i] and in_ready[i] are both 1; output transfer only when out_valid and out_ready are both 1.
REQ-014 load = !out_valid || out_ready; in_ready[i] SHALL be 1 only when load = 1 and channel i holds the grant.
REQ-015 Grant SHALL be round-robin: the first channel with in_valid = 1 searching upward from pointer ptr, wrapping from N-1 to 0.
REQ-016 When a grant to channel g is accepted, ptr SHALL become (g+1) mod N on the next edge; otherwise ptr SHALL hold.
REQ-017 Latency SHALL be exactly one cycle: payload accepted at edge k appears on out_data/out_sel with out_valid = 1 after edge k.
REQ-018 If load = 1 and no channel is valid, out_valid SHALL become 0; out_data/out_sel SHALL hold their previous values.
REQ-019 If out_valid = 1 and out_ready = 0, out_valid/out_data/out_sel SHALL hold and all in_ready SHALL be 0.
REQ-020 Simultaneous output drain and new accept in the same cycle SHALL sustain one transfer per cycle with no bubble.
REQ-021 in_ready SHALL not depend combinationally on in_data; its dependence on out_ready is permitted.
REQ-022 A requester that holds in_valid = 1 SHALL be granted within N accepted transfers (starvation-free).

Reset
REQ-023 While reset = 1 at an edge: out_valid SHALL be 0, out_data all-zero, out_sel 0, ptr 0.
REQ-024 During a reset cycle in_ready SHALL be all-zero; a payload held in the output register at reset SHALL be discarded.
REQ-025 First grant after reset release SHALL search from channel 0.

Configuration
REQ-026 Macro ARB_MUX_FIXED_PRIO_EN, when defined, SHALL replace round-robin with fixed priority (lowest valid index wins, ptr removed or held at 0); REQ-022 then does not apply.
REQ-027 Without ARB_MUX_FIXED_PRIO_EN the round-robin behaviour of REQ-015/016 SHALL apply.

Structure
REQ-028 Shared package arb_mux_pkg SHALL hold a function computing SEL_W from N and the default WIDTH/N constants.
REQ-029 Grant computation (pointer, search, one-hot and index outputs) SHALL be a sub-module rr_arbiter; arb_mux holds the data select and output register.

Verification
REQ-030 Reset then single request: in_valid=4'b0100, in_data[2]=32'hDEAD_BEEF, out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=32'hDEAD_BEEF, out_sel=2.
REQ-031 Fairness: in_valid=4'b1111 held, out_ready=1, 8 cycles -> out_sel sequence 0,1,2,3,0,1,2,3 with no gap cycles.
REQ-032 Backpressure: out_valid=1, out_ready=0 for 3 cycles with in_valid=4'b0011 -> in_ready=0, out_data/out_sel stable; on out_ready=1 next channel transfers without bubble.
REQ-033 Wrap: ptr=3, in_valid=4'b0001 -> channel 0 granted, ptr becomes 1.
REQ-034 Reset mid-stream: out_valid=1 holding channel 1 data, reset asserted one cycle -> out_valid=0, out_data=0, out_sel=0; post-reset grant of in_valid=4'b1010 selects channel 1.
REQ-035 With ARB_MUX_FIXED_PRIO_EN: in_valid=4'b1111 held, out_ready=1 -> out_sel constant 0 every cycle.
